rs_multi_cdb: RTL and testbench



---
 rtl/rs_multi_cdb.sv | 199 +++++++++++++++++++
 tb/tb_rs_multi_cdb.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_multi_cdb.sv
// Reservation station with N_CDB wakeup channels, oldest-first selection via
// an age matrix, and a registered valid/ready issue port towards one FU.
module rs_multi_cdb #(
  parameter int DEPTH    = 8,
  parameter int N_CDB    = 2,
  parameter int ROB_BITS = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      flush_in,
  input  logic                      alloc_valid,
  input  logic [6:0]                alloc_op_type,
  input  logic [2:0]                alloc_op,
  input  logic                      alloc_op_add,
  input  logic [31:0]               alloc_v1,
  input  logic [31:0]               alloc_v2,
  input  logic                      alloc_dep1,
  input  logic                      alloc_dep2,
  input  logic [ROB_BITS-1:0]       alloc_q1,
  input  logic [ROB_BITS-1:0]       alloc_q2,
  input  logic [ROB_BITS-1:0]       alloc_rd_rob,
  input  logic [31:0]               alloc_pc,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    count,
  input  logic [N_CDB-1:0]          cdb_valid,
  input  logic [N_CDB*ROB_BITS-1:0] cdb_tag,
  input  logic [N_CDB*32-1:0]       cdb_value,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [6:0]                iss_op_type,
  output logic [2:0]                iss_op,
  output logic                      iss_op_add,
  output logic [31:0]               iss_v1,
  output logic [31:0]               iss_v2,
  output logic [ROB_BITS-1:0]       iss_rd_rob,
  output logic [31:0]               iss_pc
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  // Returns {hit, value}; the descending scan leaves the lowest matching channel.
  function automatic logic [32:0] cdb_lookup(
    input logic [ROB_BITS-1:0]       tag,
    input logic [N_CDB-1:0]          vld,
    input logic [N_CDB*ROB_BITS-1:0] tags,
    input logic [N_CDB*32-1:0]       vals
  );
    logic [32:0] hit;
    hit = '0;
    for (int k = N_CDB - 1; k >= 0; k--) begin
      if (vld[k] && (tags[k*ROB_BITS +: ROB_BITS] == tag)) begin
        hit = {1'b1, vals[k*32 +: 32]};
      end
    end
    return hit;
  endfunction

  logic [DEPTH-1:0]    busy_reg;
  logic [DEPTH-1:0]    dep1_reg;
  logic [DEPTH-1:0]    dep2_reg;
  logic [DEPTH-1:0]    op_add_reg;
  logic [6:0]          op_type_reg [DEPTH];
  logic [2:0]          op_reg      [DEPTH];
  logic [31:0]         v1_reg      [DEPTH];
  logic [31:0]         v2_reg      [DEPTH];
  logic [31:0]         pc_reg      [DEPTH];
  logic [ROB_BITS-1:0] q1_reg      [DEPTH];
  logic [ROB_BITS-1:0] q2_reg      [DEPTH];
  logic [ROB_BITS-1:0] rd_rob_reg  [DEPTH];
  // older_reg[i][j] set means entry j was accepted before entry i.
  logic [DEPTH-1:0]    older_reg   [DEPTH];
  logic [CW-1:0]       count_reg;

  logic                iss_valid_reg;
  logic [6:0]          iss_op_type_reg;
  logic [2:0]          iss_op_reg;
  logic                iss_op_add_reg;
  logic [31:0]         iss_v1_reg;
  logic [31:0]         iss_v2_reg;
  logic [ROB_BITS-1:0] iss_rd_rob_reg;
  logic [31:0]         iss_pc_reg;

  logic [32:0]         wake1 [DEPTH];
  logic [32:0]         wake2 [DEPTH];
  logic [DEPTH-1:0]    ready;
  logic [DEPTH-1:0]    sel_onehot;
  logic [32:0]         byp1;
  logic [32:0]         byp2;
  logic [IW-1:0]       sel_idx;
  logic [IW-1:0]       free_idx;
  logic                any_ready;
  logic                iss_load;
  logic                alloc_fire;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign wake1[gi]      = cdb_lookup(q1_reg[gi], cdb_valid, cdb_tag, cdb_value);
    assign wake2[gi]      = cdb_lookup(q2_reg[gi], cdb_valid, cdb_tag, cdb_value);
    assign ready[gi]      = busy_reg[gi] && !dep1_reg[gi] && !dep2_reg[gi];
    assign sel_onehot[gi] = ready[gi] && !(|(older_reg[gi] & ready));
  end

  assign byp1 = cdb_lookup(alloc_q1, cdb_valid, cdb_tag, cdb_value);
  assign byp2 = cdb_lookup(alloc_q2, cdb_valid, cdb_tag, cdb_value);

  always_comb begin
    sel_idx  = '0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (sel_onehot[i]) sel_idx = IW'(i);
      if (!busy_reg[i])  free_idx = IW'(i);
    end
  end

  assign any_ready  = |ready;
  assign full       = (count_reg == CW'(DEPTH));
  assign count      = count_reg;
  assign alloc_fire = alloc_valid && !full && rdy_in && !flush_in;
  assign iss_load   = rdy_in && !flush_in && (!iss_valid_reg || iss_ready) && any_ready;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy_reg        <= '0;
      dep1_reg        <= '0;
      dep2_reg        <= '0;
      count_reg       <= '0;
      iss_valid_reg   <= 1'b0;
      iss_op_type_reg <= '0;
      iss_op_reg      <= '0;
      iss_op_add_reg  <= 1'b0;
      iss_v1_reg      <= '0;
      iss_v2_reg      <= '0;
      iss_rd_rob_reg  <= '0;
      iss_pc_reg      <= '0;
      for (int i = 0; i < DEPTH; i++) older_reg[i] <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        busy_reg      <= '0;
        count_reg     <= '0;
        iss_valid_reg <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (busy_reg[i] && dep1_reg[i] && wake1[i][32]) begin
            dep1_reg[i] <= 1'b0;
            v1_reg[i]   <= wake1[i][31:0];
          end
          if (busy_reg[i] && dep2_reg[i] && wake2[i][32]) begin
            dep2_reg[i] <= 1'b0;
            v2_reg[i]   <= wake2[i][31:0];
          end
        end

        if (iss_load) begin
          busy_reg[sel_idx] <= 1'b0;
          iss_valid_reg     <= 1'b1;
          iss_op_type_reg   <= op_type_reg[sel_idx];
          iss_op_reg        <= op_reg[sel_idx];
          iss_op_add_reg    <= op_add_reg[sel_idx];
          iss_v1_reg        <= v1_reg[sel_idx];
          iss_v2_reg        <= v2_reg[sel_idx];
          iss_rd_rob_reg    <= rd_rob_reg[sel_idx];
          iss_pc_reg        <= pc_reg[sel_idx];
        end else if (iss_ready) begin
          iss_valid_reg <= 1'b0;
        end

        if (alloc_fire) begin
          busy_reg[free_idx]    <= 1'b1;
          op_type_reg[free_idx] <= alloc_op_type;
          op_reg[free_idx]      <= alloc_op;
          op_add_reg[free_idx]  <= alloc_op_add;
          pc_reg[free_idx]      <= alloc_pc;
          rd_rob_reg[free_idx]  <= alloc_rd_rob;
          q1_reg[free_idx]      <= alloc_q1;
          q2_reg[free_idx]      <= alloc_q2;
          dep1_reg[free_idx]    <= alloc_dep1 && !byp1[32];
          dep2_reg[free_idx]    <= alloc_dep2 && !byp2[32];
          v1_reg[free_idx]      <= (alloc_dep1 && byp1[32]) ? byp1[31:0] : alloc_v1;
          v2_reg[free_idx]      <= (alloc_dep2 && byp2[32]) ? byp2[31:0] : alloc_v2;
          // Clearing the column drops stale age bits left by the slot's previous owner.
          for (int i = 0; i < DEPTH; i++) older_reg[i][free_idx] <= 1'b0;
          older_reg[free_idx] <= busy_reg;
        end

        count_reg <= count_reg + CW'(alloc_fire) - CW'(iss_load);
      end
    end
  end

  assign iss_valid   = iss_valid_reg;
  assign iss_op_type = iss_op_type_reg;
  assign iss_op      = iss_op_reg;
  assign iss_op_add  = iss_op_add_reg;
  assign iss_v1      = iss_v1_reg;
  assign iss_v2      = iss_v2_reg;
  assign iss_rd_rob  = iss_rd_rob_reg;
  assign iss_pc      = iss_pc_reg;

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Bench for rs_multi_cdb: directed scenarios plus random traffic, checked
// every cycle against an age-ordered queue model of the station.
module tb_rs_multi_cdb;
  localparam int DEPTH = 8;
  localparam int N_CDB = 2;

  logic        clk_in, rst_in, rdy_in, flush_in;
  logic        alloc_valid, alloc_op_add, alloc_dep1, alloc_dep2;
  logic [6:0]  alloc_op_type;
  logic [2:0]  alloc_op;
  logic [31:0] alloc_v1, alloc_v2, alloc_pc;
  logic [3:0]  alloc_q1, alloc_q2, alloc_rd_rob;
  logic        full;
  logic [3:0]  count;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic        iss_valid, iss_ready, iss_op_add;
  logic [6:0]  iss_op_type;
  logic [2:0]  iss_op;
  logic [31:0] iss_v1, iss_v2, iss_pc;
  logic [3:0]  iss_rd_rob;

  rs_multi_cdb #(.DEPTH(DEPTH), .N_CDB(N_CDB), .ROB_BITS(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .alloc_valid(alloc_valid), .alloc_op_type(alloc_op_type), .alloc_op(alloc_op),
    .alloc_op_add(alloc_op_add), .alloc_v1(alloc_v1), .alloc_v2(alloc_v2),
    .alloc_dep1(alloc_dep1), .alloc_dep2(alloc_dep2), .alloc_q1(alloc_q1),
    .alloc_q2(alloc_q2), .alloc_rd_rob(alloc_rd_rob), .alloc_pc(alloc_pc),
    .full(full), .count(count), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_value(cdb_value), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op_type(iss_op_type), .iss_op(iss_op), .iss_op_add(iss_op_add),
    .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_rd_rob(iss_rd_rob), .iss_pc(iss_pc)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [6:0]  op_type;
    logic [2:0]  op;
    logic        op_add;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        dep1;
    logic        dep2;
    logic [3:0]  q1;
    logic [3:0]  q2;
    logic [3:0]  rd;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];        // waiting entries, oldest first
  ent_t m_iss;
  bit   m_iss_valid;
  int   checks = 0;
  int   errors = 0;
  int   drops  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cdb_hit(input logic [3:0] tag, output logic [31:0] val);
    for (int k = 0; k < N_CDB; k++) begin
      if (cdb_valid[k] && cdb_tag[k*4 +: 4] == tag) begin
        val = cdb_value[k*32 +: 32];
        return 1'b1;
      end
    end
    val = '0;
    return 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    ent_t        e;
    int          sel;
    bit          was_full;
    logic [31:0] val;
    if (!rst_in) begin
      mq.delete();
      m_iss_valid = 1'b0;
      m_iss       = '0;
      return;
    end
    if (!rdy_in) return;
    if (flush_in) begin
      mq.delete();
      m_iss_valid = 1'b0;
      return;
    end
    was_full = (mq.size() == DEPTH);
    sel = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (sel < 0 && !mq[i].dep1 && !mq[i].dep2) sel = i;
    end
    if ((!m_iss_valid || iss_ready) && sel >= 0) begin
      m_iss       = mq[sel];
      m_iss_valid = 1'b1;
      mq.delete(sel);
      $display("issue rd=%0d v1=%h v2=%h pc=%h", m_iss.rd, m_iss.v1, m_iss.v2, m_iss.pc);
    end else if (iss_ready) begin
      m_iss_valid = 1'b0;
    end
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].dep1 && cdb_hit(mq[i].q1, val)) begin mq[i].dep1 = 1'b0; mq[i].v1 = val; end
      if (mq[i].dep2 && cdb_hit(mq[i].q2, val)) begin mq[i].dep2 = 1'b0; mq[i].v2 = val; end
    end
    if (alloc_valid) begin
      if (was_full) begin
        drops++;
      end else begin
        e.op_type = alloc_op_type; e.op = alloc_op; e.op_add = alloc_op_add;
        e.v1 = alloc_v1; e.v2 = alloc_v2; e.dep1 = alloc_dep1; e.dep2 = alloc_dep2;
        e.q1 = alloc_q1; e.q2 = alloc_q2; e.rd = alloc_rd_rob; e.pc = alloc_pc;
        if (e.dep1 && cdb_hit(e.q1, val)) begin e.dep1 = 1'b0; e.v1 = val; end
        if (e.dep2 && cdb_hit(e.q2, val)) begin e.dep2 = 1'b0; e.v2 = val; end
        mq.push_back(e);
      end
    end
  endtask

  task automatic compare_all();
    check_eq("count", 32'(count), 32'(mq.size()));
    check_eq("full", 32'(full), 32'(mq.size() == DEPTH));
    check_eq("iss_valid", 32'(iss_valid), 32'(m_iss_valid));
    if (m_iss_valid) begin
      check_eq("iss_v1", iss_v1, m_iss.v1);
      check_eq("iss_v2", iss_v2, m_iss.v2);
      check_eq("iss_pc", iss_pc, m_iss.pc);
      check_eq("iss_rd_rob", 32'(iss_rd_rob), 32'(m_iss.rd));
      check_eq("iss_opfields", 32'({iss_op_type, iss_op, iss_op_add}),
               32'({m_iss.op_type, m_iss.op, m_iss.op_add}));
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk_in);
    #1;
    compare_all();
  endtask

  task automatic clear_in();
    rdy_in      = 1'b1;
    flush_in    = 1'b0;
    alloc_valid = 1'b0;
    cdb_valid   = '0;
    cdb_tag     = '0;
    cdb_value   = '0;
  endtask

  task automatic set_alloc(input logic [31:0] v1, input logic [31:0] v2,
                           input logic d1, input logic [3:0] q1,
                           input logic d2, input logic [3:0] q2, input logic [3:0] rd);
    alloc_valid   = 1'b1;
    alloc_v1      = v1;
    alloc_v2      = v2;
    alloc_dep1    = d1;
    alloc_q1      = q1;
    alloc_dep2    = d2;
    alloc_q2      = q2;
    alloc_rd_rob  = rd;
    alloc_pc      = $urandom;
    alloc_op_type = 7'($urandom);
    alloc_op      = 3'($urandom);
    alloc_op_add  = 1'($urandom);
  endtask

  task automatic check_iss_zero(input string tag);
    check_eq({tag, "_valid"}, 32'(iss_valid), 32'd0);
    check_eq({tag, "_count"}, 32'(count), 32'd0);
    check_eq({tag, "_full"}, 32'(full), 32'd0);
    check_eq({tag, "_v1"}, iss_v1, 32'd0);
    check_eq({tag, "_v2"}, iss_v2, 32'd0);
    check_eq({tag, "_pc"}, iss_pc, 32'd0);
    check_eq({tag, "_rd"}, 32'(iss_rd_rob), 32'd0);
  endtask

  initial begin
    rst_in = 1'b0;
    iss_ready = 1'b0;
    clear_in();
    set_alloc(0, 0, 0, 0, 0, 0, 0);
    alloc_valid = 1'b0;

    // Reset then idle
    step(); step();
    check_iss_zero("reset");
    rst_in = 1'b1;
    step();

    // Ready alloc: two-cycle latency
    iss_ready = 1'b1;
    set_alloc(32'd5, 32'd7, 0, 0, 0, 0, 4'd3);
    step();
    check_eq("lat_e0_valid", 32'(iss_valid), 32'd0);
    check_eq("lat_e0_count", 32'(count), 32'd1);
    clear_in();
    step();
    check_eq("lat_e1_valid", 32'(iss_valid), 32'd1);
    check_eq("lat_e1_v1", iss_v1, 32'd5);
    check_eq("lat_e1_v2", iss_v2, 32'd7);
    check_eq("lat_e1_rd", 32'(iss_rd_rob), 32'd3);
    check_eq("lat_e1_count", 32'(count), 32'd0);
    step();

    // Wakeup two cycles after alloc via channel 1
    set_alloc(32'd0, 32'd9, 1, 4'd6, 0, 0, 4'd4);
    step();
    clear_in();
    step();
    cdb_valid = 2'b10; cdb_tag = {4'd6, 4'd0}; cdb_value = {32'hAB, 32'h0};
    step();
    check_eq("wake_not_yet", 32'(iss_valid), 32'd0);
    clear_in();
    step();
    check_eq("wake_valid", 32'(iss_valid), 32'd1);
    check_eq("wake_v1", iss_v1, 32'hAB);
    step();

    // Bypass: broadcast in the alloc cycle
    set_alloc(32'd0, 32'd9, 1, 4'd6, 0, 0, 4'd5);
    cdb_valid = 2'b10; cdb_tag = {4'd6, 4'd0}; cdb_value = {32'hCD, 32'h0};
    step();
    clear_in();
    step();
    check_eq("byp_valid", 32'(iss_valid), 32'd1);
    check_eq("byp_v1", iss_v1, 32'hCD);
    step();

    // Ordering with simultaneous CDB broadcasts of the same tag
    iss_ready = 1'b0;
    set_alloc(32'd0, 32'h5, 1, 4'd2, 0, 0, 4'd10); step();
    set_alloc(32'd1, 32'h2, 0, 0, 0, 0, 4'd11);    step();
    set_alloc(32'd3, 32'h0, 0, 0, 1, 4'd2, 4'd12); step();
    check_eq("ord_first", 32'(iss_rd_rob), 32'd11);
    clear_in();
    cdb_valid = 2'b11; cdb_tag = {4'd2, 4'd2}; cdb_value = {32'h22, 32'h11};
    step();
    check_eq("ord_hold", 32'(iss_rd_rob), 32'd11);
    clear_in();
    iss_ready = 1'b1;
    step();
    check_eq("ord_second", 32'(iss_rd_rob), 32'd10);
    check_eq("ord_a_v1", iss_v1, 32'h11);
    step();
    check_eq("ord_third", 32'(iss_rd_rob), 32'd12);
    check_eq("ord_c_v2", iss_v2, 32'h11);
    step();
    check_eq("ord_empty", 32'(iss_valid), 32'd0);

    // Fill to full under backpressure, then drain in age order
    iss_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_alloc($urandom, $urandom, 0, 0, 0, 0, 4'(i));
      step();
    end
    check_eq("full_flag", 32'(full), 32'd1);
    check_eq("full_count", 32'(count), 32'd8);
    clear_in();
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_rd", 32'(iss_rd_rob), 32'd0);
    end
    iss_ready = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      check_eq("drain_order", 32'(iss_rd_rob), 32'(j));
    end
    step();
    check_eq("drain_empty", 32'(iss_valid), 32'd0);

    // Flush with a concurrent alloc
    iss_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_alloc($urandom, $urandom, 0, 0, 0, 0, 4'(i));
      step();
    end
    check_eq("pre_flush_count", 32'(count), 32'd5);
    set_alloc(32'd1, 32'd1, 0, 0, 0, 0, 4'd9);
    flush_in = 1'b1;
    step();
    check_eq("flush_count", 32'(count), 32'd0);
    check_eq("flush_valid", 32'(iss_valid), 32'd0);
    clear_in();
    iss_ready = 1'b1;
    step();
    check_eq("flush_ghost", 32'(iss_valid), 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rdy_in      = ($urandom_range(0, 9) != 0);
      flush_in    = ($urandom_range(0, 49) == 0);
      iss_ready   = ($urandom_range(0, 9) < 6);
      set_alloc($urandom, $urandom, 1'($urandom), 4'($urandom_range(0, 7)),
                1'($urandom), 4'($urandom_range(0, 7)), 4'($urandom));
      alloc_valid = 1'($urandom);
      cdb_valid   = 2'($urandom);
      cdb_tag     = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      cdb_value   = {$urandom, $urandom};
      step();
    end

    // Reset after activity
    clear_in();
    rst_in = 1'b0;
    step(); step();
    check_iss_zero("rereset");

    $display("allocs dropped while full: %0d", drops);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
